// File: rtl/gfx_pixel_serializer_pkg.sv
// rtl/gfx_pixel_serializer_pkg.sv - shared widths, bank record and head-pixel helper
package gfx_pixel_serializer_pkg;

   localparam int GFX_PLANES = 4;
   localparam int GFX_TILE_W = 8;
   localparam int GFX_COL_W  = 4;
   localparam int GFX_DIN_W  = GFX_PLANES * GFX_TILE_W;
   localparam int GFX_CNT_W  = $clog2(GFX_TILE_W + 1);
   localparam int GFX_PIX_W  = GFX_COL_W + GFX_PLANES;

   typedef struct packed {
      logic [GFX_DIN_W-1:0] data;
      logic [GFX_COL_W-1:0] col;
      logic                 dir;
      logic [GFX_CNT_W-1:0] cnt;
   } bank_state_t;

   // dir=1 presents bit 0 of every plane, dir=0 presents bit 7; an empty bank shows 0
   function automatic logic [GFX_PLANES-1:0] head_pixel(input bank_state_t s);
      logic [GFX_PLANES-1:0] pix;
      pix = '0;
      for (int p = 0; p < GFX_PLANES; p++) begin
         pix[p] = s.dir ? s.data[p*GFX_TILE_W] : s.data[p*GFX_TILE_W + GFX_TILE_W - 1];
      end
      if (s.cnt == '0) pix = '0;
      return pix;
   endfunction

endpackage

// File: rtl/gfx_pixel_serializer_if.sv
// rtl/gfx_pixel_serializer_if.sv - pixel serializer control, data and output bundle
interface gfx_pixel_serializer_if;
   import gfx_pixel_serializer_pkg::*;

   logic                 Cen;
   logic                 PLOAD_RSHIFTn;
   logic                 RL_Sel;
   logic                 AB_Sel;
   logic                 VDG;
   logic                 VLK;
   logic                 G15_CE;
   logic [GFX_DIN_W-1:0] DIN;
   logic [GFX_COL_W-1:0] COL_IN;
   logic [GFX_PIX_W-1:0] PIX_OUT;
   logic                 UNDERRUN;

   modport master (
      output Cen, PLOAD_RSHIFTn, RL_Sel, AB_Sel, VDG, VLK, G15_CE, DIN, COL_IN,
      input  PIX_OUT, UNDERRUN
   );

   modport slave (
      input  Cen, PLOAD_RSHIFTn, RL_Sel, AB_Sel, VDG, VLK, G15_CE, DIN, COL_IN,
      output PIX_OUT, UNDERRUN
   );
endinterface

// File: rtl/gfx_pixel_serializer_pixel_shift_bank.sv
// rtl/gfx_pixel_serializer_pixel_shift_bank.sv - one tile bank: load, directional shift, count, head pixel
module pixel_shift_bank
   import gfx_pixel_serializer_pkg::*;
(
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  load,
   input  logic                  shift,
   input  logic [GFX_DIN_W-1:0]  din,
   input  logic [GFX_COL_W-1:0]  col_in,
   input  logic                  dir_in,
   output logic [GFX_PLANES-1:0] head,
   output logic [GFX_COL_W-1:0]  col,
   output logic                  empty
);

   bank_state_t              state;
   bank_state_t              nxt;
   logic [GFX_TILE_W-1:0]    plane;

   always_comb begin
      nxt   = state;
      plane = '0;
      if (load) begin
         nxt.data = din;
         nxt.col  = col_in;
         nxt.dir  = dir_in;
         nxt.cnt  = GFX_CNT_W'(GFX_TILE_W);
      end else if (shift && state.cnt != '0) begin
         // an empty bank holds at count 0 instead of wrapping
         for (int p = 0; p < GFX_PLANES; p++) begin
            plane = state.data[p*GFX_TILE_W +: GFX_TILE_W];
            nxt.data[p*GFX_TILE_W +: GFX_TILE_W] = state.dir ? (plane >> 1) : (plane << 1);
         end
         nxt.cnt = state.cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) state <= '0;
      else       state <= nxt;
   end

   assign head  = head_pixel(state);
   assign col   = state.col;
   assign empty = (state.cnt == '0);

endmodule

// File: rtl/gfx_pixel_serializer.sv
// rtl/gfx_pixel_serializer.sv - ping-pong bitplane tile serializer with tick detect and output register
module gfx_pixel_serializer
   import gfx_pixel_serializer_pkg::*;
(
   input  logic                  clk,
   input  logic                  Reset,
   gfx_pixel_serializer_if.slave bus
);

   logic                  cen_q;
   logic                  tick;
   logic                  load_a, load_b, shift_a, shift_b;
   logic [GFX_PLANES-1:0] head_a, head_b, drv_head;
   logic [GFX_COL_W-1:0]  col_a, col_b, drv_col;
   logic                  empty_a, empty_b, drv_empty;
   logic [GFX_PIX_W-1:0]  pix_q;
   logic                  underrun_q;

   // edge register resets high so a Cen already high at release is not a tick
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) cen_q <= 1'b1;
      else       cen_q <= bus.Cen;
   end

   assign tick = bus.Cen & ~cen_q;

   // AB_Sel=0: A fills, B drives; AB_Sel=1: B fills, A drives
   assign load_a  = tick & ~bus.PLOAD_RSHIFTn & ~bus.AB_Sel;
   assign load_b  = tick & ~bus.PLOAD_RSHIFTn &  bus.AB_Sel;
   assign shift_a = tick &  bus.AB_Sel;
   assign shift_b = tick & ~bus.AB_Sel;

   pixel_shift_bank u_bank_a (
      .clk    (clk),
      .Reset  (Reset),
      .load   (load_a),
      .shift  (shift_a),
      .din    (bus.DIN),
      .col_in (bus.COL_IN),
      .dir_in (bus.RL_Sel),
      .head   (head_a),
      .col    (col_a),
      .empty  (empty_a)
   );

   pixel_shift_bank u_bank_b (
      .clk    (clk),
      .Reset  (Reset),
      .load   (load_b),
      .shift  (shift_b),
      .din    (bus.DIN),
      .col_in (bus.COL_IN),
      .dir_in (bus.RL_Sel),
      .head   (head_b),
      .col    (col_b),
      .empty  (empty_b)
   );

   assign drv_head  = bus.AB_Sel ? head_a  : head_b;
   assign drv_col   = bus.AB_Sel ? col_a   : col_b;
   assign drv_empty = bus.AB_Sel ? empty_a : empty_b;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         pix_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= tick & drv_empty;
         if (tick & bus.G15_CE & ~bus.VLK)
            pix_q <= {drv_col, bus.VDG ? {GFX_PLANES{1'b0}} : drv_head};
      end
   end

   assign bus.PIX_OUT  = pix_q;
   assign bus.UNDERRUN = underrun_q;

endmodule

// File: tb/tb_gfx_pixel_serializer.sv
// tb/tb_gfx_pixel_serializer.sv - scoreboard bench with a pixel-list reference model
module tb_gfx_pixel_serializer;
   import gfx_pixel_serializer_pkg::*;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   gfx_pixel_serializer_if bus();

   gfx_pixel_serializer dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] pix;
      logic       ur;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model: each bank is an ordered list of 8 pixels plus remaining count (0 = A, 1 = B)
   logic [3:0] m_seq[2][8];
   int         m_rem[2];
   logic [3:0] m_col[2];
   logic [7:0] m_out;

   logic       mon_cen_prev = 1'b1;
   logic       mon_tick;
   logic [7:0] mon_hold = 8'h00;
   exp_t       mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_rem[b] = 0;
         m_col[b] = 4'h0;
         for (int k = 0; k < 8; k++) m_seq[b][k] = 4'h0;
      end
      m_out = 8'h00;
   endtask

   task automatic scramble();
      bus.PLOAD_RSHIFTn = 1'($urandom);
      bus.RL_Sel        = 1'($urandom);
      bus.AB_Sel        = 1'($urandom);
      bus.VDG           = 1'($urandom);
      bus.VLK           = 1'($urandom);
      bus.G15_CE        = 1'($urandom);
      bus.DIN           = $urandom;
      bus.COL_IN        = 4'($urandom);
   endtask

   task automatic tick(input logic pl_n, input logic rl, input logic ab, input logic vdg,
                       input logic vlk, input logic g15, input logic [31:0] din,
                       input logic [3:0] col, input int hold);
      int         drv;
      int         fil;
      int         bi;
      logic [3:0] px;
      logic       ur;
      @(negedge clk);
      bus.Cen = 1'b1;
      bus.PLOAD_RSHIFTn = pl_n;
      bus.RL_Sel = rl;
      bus.AB_Sel = ab;
      bus.VDG = vdg;
      bus.VLK = vlk;
      bus.G15_CE = g15;
      bus.DIN = din;
      bus.COL_IN = col;
      drv = ab ? 0 : 1;
      fil = ab ? 1 : 0;
      if (m_rem[drv] == 0) begin
         px = 4'h0;
         ur = 1'b1;
      end else begin
         px = m_seq[drv][8 - m_rem[drv]];
         m_rem[drv]--;
         ur = 1'b0;
      end
      if (g15 && !vlk) m_out = {m_col[drv], vdg ? 4'h0 : px};
      if (!pl_n) begin
         for (int k = 0; k < 8; k++) begin
            bi = rl ? k : 7 - k;
            m_seq[fil][k] = {din[24+bi], din[16+bi], din[8+bi], din[bi]};
         end
         m_rem[fil] = 8;
         m_col[fil] = col;
      end
      exp_q.push_back('{m_out, ur});
      // inputs outside the tick cycle must be ignored, Cen held high is one tick
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         scramble();
      end
      @(negedge clk);
      bus.Cen = 1'b0;
      scramble();
   endtask

   task automatic run_tile(input logic rl, input logic [31:0] din, input logic [3:0] col);
      tick(1'b0, rl, 1'b0, 1'b0, 1'b0, 1'b1, din, col, 1);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, 4'h0, 1);
   endtask

   // monitor: compare one clk after every tick, otherwise the output must hold
   initial begin
      forever begin
         @(posedge clk);
         mon_tick     = !Reset && bus.Cen && !mon_cen_prev;
         mon_cen_prev = Reset ? 1'b1 : bus.Cen;
         #1;
         if (Reset) begin
            check("reset_pix", bus.PIX_OUT, 8'h00);
            check("reset_underrun", bus.UNDERRUN, 1'b0);
            mon_hold = 8'h00;
         end else if (mon_tick) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tick: got output %0h with no expectation queued", bus.PIX_OUT);
            end else begin
               mon_e = exp_q.pop_front();
               check("pix_out", bus.PIX_OUT, mon_e.pix);
               check("underrun", bus.UNDERRUN, mon_e.ur);
               mon_hold = mon_e.pix;
            end
         end else begin
            check("hold_pix", bus.PIX_OUT, mon_hold);
            check("idle_underrun", bus.UNDERRUN, 1'b0);
         end
      end
   end

   initial begin
      logic ab;
      Reset = 1'b1;
      bus.Cen = 1'b0;
      bus.PLOAD_RSHIFTn = 1'b1;
      bus.RL_Sel = 1'b0;
      bus.AB_Sel = 1'b0;
      bus.VDG = 1'b0;
      bus.VLK = 1'b0;
      bus.G15_CE = 1'b1;
      bus.DIN = '0;
      bus.COL_IN = '0;
      model_reset();
      repeat (3) @(negedge clk);
      Reset = 1'b0;

      run_tile(1'b1, 32'hFF00_F0AA, 4'h5);
      run_tile(1'b0, 32'hFF00_F0AA, 4'h5);

      // ping-pong: B fills during A's output, then swap
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 4'h3, 1);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h9ABC_DEF0, 4'hA, 2);
      for (int i = 2; i <= 8; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, 4'h0, 1);
      for (int i = 9; i <= 16; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 4'h0, 1);

      // gating: VDG on 3, VLK on 4, G15_CE low on 5
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5C3_3C5A, 4'h9, 1);
      for (int i = 1; i <= 8; i++)
         tick(1'b1, 1'b0, 1'b1, i == 3, i == 4, i != 5, $urandom, 4'h0, 1);

      ab = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) ab = ~ab;
         tick($urandom_range(2) != 0, 1'($urandom), ab, $urandom_range(5) == 0,
              $urandom_range(7) == 0, $urandom_range(7) != 0, $urandom, 4'($urandom),
              $urandom_range(1, 3));
      end

      // reset mid-tile with Cen held high through release
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hE, 1);
      for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, 4'h0, 1);
      @(negedge clk);
      Reset = 1'b1;
      bus.Cen = 1'b1;
      #1;
      check("async_reset_pix", bus.PIX_OUT, 8'h00);
      check("async_reset_underrun", bus.UNDERRUN, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      Reset = 1'b0;
      repeat (3) @(negedge clk);
      bus.Cen = 1'b0;
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, 4'h0, 1);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 4'h0, 1);

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
